// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_WIDTH  = 8;
  localparam int unsigned UART_ARB_NUM_REQ = 4;
  localparam int unsigned UART_ARB_TIMEOUT = 255;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: one-hot select of the first request strictly after ptr,
// wrapping around, plus an any-request flag.
module uart_rr_picker #(
  parameter int unsigned P_NUM_REQ = 4,
  parameter int unsigned P_PTR_W   = 2
) (
  input  logic [P_NUM_REQ-1:0] req,
  input  logic [P_PTR_W-1:0]   ptr,
  output logic [P_NUM_REQ-1:0] pick,
  output logic                 any
);

  logic               found;
  logic [P_PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    // Walk ptr+1 .. ptr+N so ptr itself is visited last (lowest priority).
    for (int unsigned i = 1; i <= P_NUM_REQ; i++) begin
      idx = P_PTR_W'((32'(ptr) + i) % P_NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter byte port
// among P_NUM_REQ requesters, with forced release after an idle timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned P_UART_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned P_NUM_REQ         = UART_ARB_NUM_REQ,
  parameter int unsigned P_IDLE_TIMEOUT    = UART_ARB_TIMEOUT
) (
  input  logic                                   i_u_clk,
  input  logic                                   i_u_rst,
  input  logic [P_NUM_REQ*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]                   i_req_valid,
  input  logic [P_NUM_REQ-1:0]                   i_req_last,
  output logic [P_NUM_REQ-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_uart_tx_data,
  output logic                                   o_uart_tx_valid,
  input  logic                                   i_uart_tx_ready,
  output logic [P_NUM_REQ-1:0]                   o_grant,
  output logic                                   o_busy,
  output logic                                   o_timeout
);

  localparam int unsigned         LP_PTR_W    = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int unsigned         LP_CNT_W    = $clog2(P_IDLE_TIMEOUT + 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_IDLE_TIMEOUT - 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_MAX  = '1;

  arb_state_t                   state_q, state_d;
  logic [P_NUM_REQ-1:0]         grant_q, grant_d;
  logic [P_NUM_REQ-1:0]         pick;
  logic                         pick_any;
  logic [LP_PTR_W-1:0]          ptr_q, ptr_d;
  logic [LP_PTR_W-1:0]          owner_idx;
  logic [LP_CNT_W-1:0]          cnt_q, cnt_d;
  logic                         timeout_q, timeout_d;
  logic [P_UART_DATA_WIDTH-1:0] own_data;
  logic                         own_valid;
  logic                         own_last;
  logic                         xfer;

  uart_rr_picker #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_PTR_W   (LP_PTR_W)
  ) u_picker (
    .req  (i_req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  // Owner selection follows the registered one-hot grant (all-zero when idle).
  always_comb begin
    own_data  = '0;
    owner_idx = '0;
    for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
      if (grant_q[k]) begin
        own_data  = i_req_data[k*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
        owner_idx = LP_PTR_W'(k);
      end
    end
    own_valid = |(i_req_valid & grant_q);
    own_last  = |(i_req_last & grant_q);
    xfer      = (state_q == S_GRANT) && own_valid && i_uart_tx_ready;
  end

  assign o_uart_tx_valid = (state_q == S_GRANT) && own_valid;
  assign o_uart_tx_data  = (state_q == S_GRANT) ? own_data : '0;
  assign o_req_ready     = ((state_q == S_GRANT) && i_uart_tx_ready) ? grant_q : '0;
  assign o_grant         = grant_q;
  assign o_busy          = (state_q == S_GRANT);
  assign o_timeout       = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = owner_idx;
          end
        end else if (!own_valid) begin
          // Backpressure (valid high, ready low) neither counts nor clears.
          if (cnt_q == LP_CNT_LAST) begin
            state_d   = S_IDLE;
            grant_d   = '0;
            ptr_d     = owner_idx;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (cnt_q != LP_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= LP_PTR_W'(P_NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface among P_NUM_REQ independent requesters.
- Each requester offers a packet as a stream of bytes, with a last flag on the final byte.
- Grants are round-robin and packet-atomic: a granted requester keeps the transmitter until its last byte is accepted, or until an idle timeout forces release.
- Sits between the user-side byte sources and the transmitter input, on the i_u_clk domain.

Parameters:
- P_UART_DATA_WIDTH, `UART_DATA_WIDTH (8), byte width per requester and on the transmitter side.
- P_NUM_REQ, 4, number of requesters, range 2..8.
- P_IDLE_TIMEOUT, 255, cycles a granted requester may hold valid low mid-packet before forced release; range 1..65535.

Ports:
- i_u_clk  in  1  clock.
- i_u_rst  in  1  reset, asynchronous, active-high.
- i_req_data  in  P_NUM_REQ*P_UART_DATA_WIDTH  packed bytes; requester k occupies bits [k*W +: W].
- i_req_valid  in  P_NUM_REQ  byte valid per requester.
- i_req_last  in  P_NUM_REQ  final byte of packet, qualified by valid.
- o_req_ready  out  P_NUM_REQ  byte accepted when valid & ready.
- o_uart_tx_data  out  P_UART_DATA_WIDTH  byte to the transmitter.
- o_uart_tx_valid  out  1  byte present for the transmitter.
- i_uart_tx_ready  in  1  transmitter can accept a byte this cycle.
- o_grant  out  P_NUM_REQ  one-hot current owner; all zero when idle.
- o_busy  out  1  state == S_GRANT.
- o_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, i_u_rst=1):
  - state = S_IDLE; o_grant = 0; RR pointer = P_NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0; o_timeout = 0.
  - o_req_ready = 0; o_uart_tx_valid = 0; o_uart_tx_data = 0.
- Reset mid-packet: the grant is dropped immediately. The transmitter may already hold a partial packet; recovery is upstream's concern.
- S_IDLE:
  - If any i_req_valid is set, the picker selects the first valid requester strictly after the RR pointer, with wrap-around.
  - o_grant is registered to that requester and state moves to S_GRANT on the next edge.
  - Arbitration latency is 1 cycle. No bytes are passed in S_IDLE.
- S_GRANT, owner g (datapath is combinational pass-through, zero added latency):
  - o_uart_tx_data = i_req_data[g].
  - o_uart_tx_valid = i_req_valid[g].
  - o_req_ready[g] = i_uart_tx_ready; o_req_ready of every other requester = 0.
  - A transfer occurs when i_req_valid[g] & i_uart_tx_ready.
- Transfer with i_req_last[g]=1: next state S_IDLE, RR pointer := g, o_grant := 0. Back-to-back packets therefore have exactly 1 idle cycle between them.
- Transfer with last=0: stay in S_GRANT; timeout counter := 0.
- Idle timeout:
  - In S_GRANT with i_req_valid[g]=0, the counter increments.
  - When the counter reaches P_IDLE_TIMEOUT-1 and valid is still low, the arbiter forces release: state := S_IDLE, RR pointer := g, o_timeout pulses 1 cycle, counter := 0.
  - Cycles with valid=1 but ready=0 are transmitter backpressure: the counter holds and is never cleared by them, and they never time out.
- Counter width is clog2(P_IDLE_TIMEOUT+1). It saturates and never wraps.
- Fairness: after owner g releases, g has lowest priority in the next arbitration.
- Simultaneous events:
  - A new request arriving in the same cycle as release is considered in the next S_IDLE cycle.
  - A non-owner asserting valid while another requester is granted is ignored; its ready stays 0.
- A 1-byte packet (valid and last together on the first byte) is legal. It occupies 1 grant cycle when ready=1.

Decomposition:
- Into Uart_Defines.v: state encodings `UART_ARB_S_IDLE=1'b0 and `UART_ARB_S_GRANT=1'b1, and default `UART_ARB_NUM_REQ / `UART_ARB_TIMEOUT.
- Sub-module uart_rr_picker (combinational): inputs are the request vector and the pointer; outputs are a one-hot pick and an any flag. It is instantiated once.

Test Plan:
- Single requester, 3-byte packet:
  - Stimulus: req1 sends 0x11, 0x22, 0x33(last) with tx_ready=1.
  - Expect: grant=4'b0010 one cycle after valid; tx bytes 0x11/0x22/0x33 on consecutive cycles; then grant=0.
- Round-robin:
  - Stimulus: req0..3 each hold a 1-byte packet from reset.
  - Expect: service order 0,1,2,3, with 2 cycles per packet.
  - Then, with req0 and req2 re-requesting after req3, expect order 0,2.
- Packet atomicity:
  - Stimulus: req2 raises valid mid-way through req0's 4-byte packet.
  - Expect: all 4 req0 bytes are contiguous, req2's ready stays 0, and req2 is granted after req0's last.
- Backpressure:
  - Stimulus: tx_ready=0 for 400 cycles while owner valid=1, with P_IDLE_TIMEOUT=255.
  - Expect: no timeout, data held stable; transfer completes when ready returns.
- Timeout:
  - Stimulus: owner sends 1 byte (last=0), then drops valid; P_IDLE_TIMEOUT=16.
  - Expect: o_timeout pulse exactly 16 cycles after valid fell, then grant=0 and another pending requester is granted next.
- Async reset mid-packet:
  - Stimulus: assert i_u_rst during byte 2 of a 4-byte packet.
  - Expect: o_grant=0, tx_valid=0 and all ready=0 immediately.
  - After release, requester 0 wins first if it is requesting.
